// File: rtl/dcache_array_arb_if.sv
// -----------------------------------------------------------------------------
// dcache_array_arb_if
// Requester-side bundle of the data-cache array arbiter. Every per-port field
// is packed with port 0 in the least-significant slice.
//   req_i      NR_PORTS*SET_ASSOC  way-select mask per port (nonzero = request)
//   addr_i     NR_PORTS*INDEX_WIDTH set index per port
//   tag_i      NR_PORTS*TAG_WIDTH  late tag, used in the response cycle
//   we_i       NR_PORTS            write enable per port
//   wdata_i    NR_PORTS*EW         write entry {tag, data, valid, dirty}
//   be_i       NR_PORTS*BW         enables {tag_en, data_be, vd_en}
//   gnt_o      NR_PORTS            one-hot (or zero) grant, combinational
//   rvalid_o   NR_PORTS            read response valid, one cycle after grant
//   rdata_o    SET_ASSOC*EW        raw entries of all ways
//   hit_way_o  SET_ASSOC           tag-hit vector for the pending read
//   multihit_o 1                   sticky multiple-hit error
// Modports: master = requesters, slave = arbiter.
// -----------------------------------------------------------------------------
interface dcache_array_arb_if #(
   parameter int NR_PORTS    = 4,
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128
) ();
   localparam int EW = TAG_WIDTH + LINE_WIDTH + 2;
   localparam int BW = LINE_WIDTH / 8 + 2;

   logic [NR_PORTS*SET_ASSOC-1:0]   req_i;
   logic [NR_PORTS*INDEX_WIDTH-1:0] addr_i;
   logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i;
   logic [NR_PORTS-1:0]             we_i;
   logic [NR_PORTS*EW-1:0]          wdata_i;
   logic [NR_PORTS*BW-1:0]          be_i;
   logic [NR_PORTS-1:0]             gnt_o;
   logic [NR_PORTS-1:0]             rvalid_o;
   logic [SET_ASSOC*EW-1:0]         rdata_o;
   logic [SET_ASSOC-1:0]            hit_way_o;
   logic                            multihit_o;

   modport master (
      output req_i, addr_i, tag_i, we_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o, hit_way_o, multihit_o
   );

   modport slave (
      input  req_i, addr_i, tag_i, we_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o, hit_way_o, multihit_o
   );
endinterface

// File: rtl/dcache_array_arb.sv
// -----------------------------------------------------------------------------
// dcache_array_arb
// Arbitrates NR_PORTS requesters onto one set-associative tag/data array.
// Port 0 (miss handler) has absolute priority; ports 1..NR_PORTS-1 share the
// array round-robin. Reads return one cycle after the grant, together with a
// per-way tag-hit vector computed against the requester's late tag.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          requester bundle (dcache_array_arb_if.slave)
//   ram_req_o    per-way enable of the granted request (0 when idle)
//   ram_addr_o   set index of the granted request
//   ram_we_o     write enable of the granted request
//   ram_wdata_o  write entry {tag, data, valid, dirty}
//   ram_be_o     enables {tag_en, data_be, vd_en}
//   ram_rdata_i  entries of all ways, valid in the cycle after a read grant
// -----------------------------------------------------------------------------
module dcache_array_arb #(
   parameter int NR_PORTS    = 4,
   parameter int SET_ASSOC   = 8,
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 44,
   parameter int LINE_WIDTH  = 128
) (
   input  logic                                               clk_i,
   input  logic                                               rst_ni,
   dcache_array_arb_if.slave                                  bus,
   output logic [SET_ASSOC-1:0]                               ram_req_o,
   output logic [INDEX_WIDTH-1:0]                             ram_addr_o,
   output logic                                               ram_we_o,
   output logic [TAG_WIDTH+LINE_WIDTH+1:0]                    ram_wdata_o,
   output logic [LINE_WIDTH/8+1:0]                            ram_be_o,
   input  logic [SET_ASSOC*(TAG_WIDTH+LINE_WIDTH+2)-1:0]      ram_rdata_i
);
   localparam int EW  = TAG_WIDTH + LINE_WIDTH + 2;
   localparam int BW  = LINE_WIDTH / 8 + 2;
   localparam int IDW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   // True when more than one bit of the hit vector is set.
   function automatic logic multi_hit(input logic [SET_ASSOC-1:0] h);
      return (h & (h - SET_ASSOC'(1))) != '0;
   endfunction

   logic [NR_PORTS-1:0]  port_req;
   logic [NR_PORTS-1:0]  gnt;
   logic [IDW-1:0]       gnt_id;
   logic                 valid_q;
   logic [IDW-1:0]       id_q;
   logic                 multihit_q;
   logic [TAG_WIDTH-1:0] tag_sel;
   logic [SET_ASSOC-1:0] hit_way;
   logic [NR_PORTS-1:0]  rvalid;

   always_comb begin
      port_req = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         port_req[k] = |bus.req_i[k*SET_ASSOC +: SET_ASSOC];
      end
   end

   // ---- arbitration (grant cycle) ----
   generate
      if (NR_PORTS == 1) begin : g_single
         assign gnt = port_req;
      end else begin : g_rr
         localparam int RRW = $clog2(NR_PORTS);
         logic [RRW-1:0] rr_q;
         logic [RRW-1:0] rr_d;
         logic           found;

         // Two passes emulate a circular search starting at rr_q:
         // first ports rr_q..NR_PORTS-1, then ports 1..rr_q-1.
         always_comb begin
            gnt   = '0;
            found = 1'b0;
            rr_d  = rr_q;
            if (port_req[0]) begin
               gnt[0] = 1'b1;
            end else begin
               for (int k = 1; k < NR_PORTS; k++) begin
                  if (!found && port_req[k] && (k >= int'(rr_q))) begin
                     gnt[k] = 1'b1;
                     found  = 1'b1;
                     rr_d   = (k == NR_PORTS - 1) ? RRW'(1) : RRW'(k + 1);
                  end
               end
               for (int k = 1; k < NR_PORTS; k++) begin
                  if (!found && port_req[k] && (k < int'(rr_q))) begin
                     gnt[k] = 1'b1;
                     found  = 1'b1;
                     rr_d   = (k == NR_PORTS - 1) ? RRW'(1) : RRW'(k + 1);
                  end
               end
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               rr_q <= RRW'(1);
            end else begin
               rr_q <= rr_d;
            end
         end
      end
   endgenerate

   // RAM-side mux: AND-OR select of the granted port's fields.
   always_comb begin
      gnt_id      = '0;
      ram_req_o   = '0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      ram_be_o    = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         if (gnt[k]) begin
            gnt_id      = IDW'(k);
            ram_req_o   = bus.req_i[k*SET_ASSOC +: SET_ASSOC];
            ram_addr_o  = bus.addr_i[k*INDEX_WIDTH +: INDEX_WIDTH];
            ram_we_o    = bus.we_i[k];
            ram_wdata_o = bus.wdata_i[k*EW +: EW];
            ram_be_o    = bus.be_i[k*BW +: BW];
         end
      end
   end

   // ---- grant -> response boundary ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= 1'b0;
         id_q       <= '0;
         multihit_q <= 1'b0;
      end else begin
         valid_q <= (|gnt) & ~ram_we_o;
         id_q    <= gnt_id;
         if (valid_q && multi_hit(hit_way)) begin
            multihit_q <= 1'b1;
         end
      end
   end

   // ---- response cycle ----
   always_comb begin
      tag_sel = '0;
      rvalid  = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         if (id_q == IDW'(k)) begin
            tag_sel   = bus.tag_i[k*TAG_WIDTH +: TAG_WIDTH];
            rvalid[k] = valid_q;
         end
      end
   end

   // Entry layout per way: tag in the top bits, valid at bit 1, dirty at bit 0.
   always_comb begin
      hit_way = '0;
      for (int i = 0; i < SET_ASSOC; i++) begin
         hit_way[i] = valid_q & ram_rdata_i[i*EW + 1] &
                      (ram_rdata_i[i*EW + EW - 1 -: TAG_WIDTH] == tag_sel);
      end
   end

   assign bus.gnt_o      = gnt;
   assign bus.rvalid_o   = rvalid;
   assign bus.rdata_o    = ram_rdata_i;
   assign bus.hit_way_o  = hit_way;
   assign bus.multihit_o = multihit_q;
endmodule

// File: tb/tb_dcache_array_arb.sv
module tb_dcache_array_arb;
   localparam int NP = 4;
   localparam int SA = 8;
   localparam int IW = 12;
   localparam int TW = 44;
   localparam int LW = 128;
   localparam int EW = TW + LW + 2;
   localparam int BW = LW / 8 + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_array_arb_if #(.NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW),
                         .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus_if ();

   logic [SA-1:0]    ram_req;
   logic [IW-1:0]    ram_addr;
   logic             ram_we;
   logic [EW-1:0]    ram_wdata;
   logic [BW-1:0]    ram_be;
   logic [SA*EW-1:0] ram_rdata;

   dcache_array_arb #(.NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW),
                      .TAG_WIDTH(TW), .LINE_WIDTH(LW)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus_if.slave),
      .ram_req_o   (ram_req),
      .ram_addr_o  (ram_addr),
      .ram_we_o    (ram_we),
      .ram_wdata_o (ram_wdata),
      .ram_be_o    (ram_be),
      .ram_rdata_i (ram_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle_reqs();
      bus_if.req_i = '0;
      bus_if.we_i  = '0;
   endtask

   task automatic set_port(input int p, input logic [SA-1:0] mask, input logic we,
                           input logic [IW-1:0] addr);
      bus_if.req_i[p*SA +: SA] = mask;
      bus_if.we_i[p]           = we;
      bus_if.addr_i[p*IW +: IW] = addr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [EW-1:0] ent(input logic [TW-1:0] tag, input logic valid);
      logic [LW-1:0] data;
      data = {4{32'hC0DE0000 | 32'(tag[15:0])}};
      return {tag, data, valid, 1'b0};
   endfunction

   logic [3:0] exp_g [5];
   logic [3:0] prev_g;
   logic [EW-1:0] wentry;

   initial begin
      bus_if.req_i   = '0;
      bus_if.addr_i  = '0;
      bus_if.tag_i   = '0;
      bus_if.we_i    = '0;
      bus_if.wdata_i = '0;
      bus_if.be_i    = '0;
      ram_rdata      = '0;
      ram_rdata[0*EW +: EW] = ent(44'h0, 1'b1);  // would hit tag 0 if not gated

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid",   256'(bus_if.rvalid_o),   256'(4'b0000));
      check("rst_hit",      256'(bus_if.hit_way_o),  256'(8'h00));
      check("rst_multihit", 256'(bus_if.multihit_o), 256'(1'b0));
      check("rst_gnt_idle", 256'(bus_if.gnt_o),      256'(4'b0000));
      check("rst_ramreq",   256'(ram_req),           256'(8'h00));
      next_cycle();
      rst_n     = 1'b1;
      ram_rdata = '0;

      // port 0 beats port 2
      set_port(0, 8'h01, 1'b0, 12'h123);
      set_port(2, 8'h02, 1'b0, 12'h456);
      @(negedge clk);
      check("p0prio_gnt",  256'(bus_if.gnt_o), 256'(4'b0001));
      check("p0prio_req",  256'(ram_req),      256'(8'h01));
      check("p0prio_addr", 256'(ram_addr),     256'(12'h123));
      check("p0prio_we",   256'(ram_we),       256'(1'b0));
      next_cycle();
      idle_reqs();
      @(negedge clk);
      check("p0prio_rvalid", 256'(bus_if.rvalid_o), 256'(4'b0001));

      // rr_q still 1: port 1 wins over port 2
      next_cycle();
      set_port(1, 8'h04, 1'b0, 12'h010);
      set_port(2, 8'h02, 1'b0, 12'h020);
      @(negedge clk);
      check("rr_start_gnt",    256'(bus_if.gnt_o),    256'(4'b0010));
      check("rr_start_rvalid", 256'(bus_if.rvalid_o), 256'(4'b0000));
      check("rr_start_ramreq", 256'(ram_req),         256'(8'h04));

      // ports 1..3 continuously
      exp_g[0] = 4'b0100; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
      exp_g[3] = 4'b0100; exp_g[4] = 4'b1000;
      prev_g = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         set_port(1, 8'h04, 1'b0, 12'h010);
         set_port(2, 8'h02, 1'b0, 12'h020);
         set_port(3, 8'h80, 1'b0, 12'h030);
         @(negedge clk);
         check($sformatf("rr_gnt%0d", i),    256'(bus_if.gnt_o),    256'(exp_g[i]));
         check($sformatf("rr_rvalid%0d", i), 256'(bus_if.rvalid_o), 256'(prev_g));
         prev_g = exp_g[i];
      end
      check("rr_ramreq_p3", 256'(ram_req), 256'(8'h80));
      next_cycle();
      idle_reqs();
      @(negedge clk);
      check("rr_tail_rvalid", 256'(bus_if.rvalid_o), 256'(4'b1000));
      check("rr_tail_gnt",    256'(bus_if.gnt_o),    256'(4'b0000));

      // single hit, way 3
      next_cycle();
      set_port(1, 8'hFF, 1'b0, 12'h3C0);
      @(negedge clk);
      check("hit_gnt", 256'(bus_if.gnt_o), 256'(4'b0010));
      next_cycle();
      idle_reqs();
      bus_if.tag_i[1*TW +: TW] = 44'h1A;
      ram_rdata[3*EW +: EW] = ent(44'h1A, 1'b1);
      ram_rdata[1*EW +: EW] = ent(44'h1B, 1'b1);
      ram_rdata[2*EW +: EW] = ent(44'h1A, 1'b0);
      @(negedge clk);
      check("hit_rvalid",   256'(bus_if.rvalid_o),   256'(4'b0010));
      check("hit_way",      256'(bus_if.hit_way_o),  256'(8'h08));
      check("hit_rdata3",   256'(bus_if.rdata_o[3*EW +: EW]), 256'(ent(44'h1A, 1'b1)));
      check("hit_multihit", 256'(bus_if.multihit_o), 256'(1'b0));
      next_cycle();
      @(negedge clk);
      check("hit_gated",     256'(bus_if.hit_way_o),  256'(8'h00));
      check("hit_multihit2", 256'(bus_if.multihit_o), 256'(1'b0));

      // multihit, ways 0 and 5
      next_cycle();
      ram_rdata = '0;
      set_port(2, 8'h01, 1'b0, 12'h044);
      @(negedge clk);
      check("mh_gnt", 256'(bus_if.gnt_o), 256'(4'b0100));
      next_cycle();
      idle_reqs();
      bus_if.tag_i[2*TW +: TW] = 44'h2B;
      ram_rdata[0*EW +: EW] = ent(44'h2B, 1'b1);
      ram_rdata[5*EW +: EW] = ent(44'h2B, 1'b1);
      @(negedge clk);
      check("mh_rvalid",  256'(bus_if.rvalid_o),   256'(4'b0100));
      check("mh_hit",     256'(bus_if.hit_way_o),  256'(8'h21));
      check("mh_not_yet", 256'(bus_if.multihit_o), 256'(1'b0));
      next_cycle();
      @(negedge clk);
      check("mh_set", 256'(bus_if.multihit_o), 256'(1'b1));
      repeat (3) next_cycle();
      @(negedge clk);
      check("mh_sticky", 256'(bus_if.multihit_o), 256'(1'b1));

      // port 3 write
      next_cycle();
      wentry = {44'hABC, {4{32'h5555AAAA}}, 2'b11};
      bus_if.wdata_i[3*EW +: EW] = wentry;
      bus_if.be_i[3*BW +: BW]    = {1'b1, 16'hFFFF, 1'b1};
      set_port(3, 8'h10, 1'b1, 12'h7F0);
      @(negedge clk);
      check("wr_gnt",   256'(bus_if.gnt_o), 256'(4'b1000));
      check("wr_we",    256'(ram_we),       256'(1'b1));
      check("wr_req",   256'(ram_req),      256'(8'h10));
      check("wr_addr",  256'(ram_addr),     256'(12'h7F0));
      check("wr_be",    256'(ram_be),       256'({1'b1, 16'hFFFF, 1'b1}));
      check("wr_wdata", 256'(ram_wdata),    256'(wentry));
      next_cycle();
      idle_reqs();
      set_port(1, 8'h01, 1'b0, 12'h001);
      set_port(2, 8'h01, 1'b0, 12'h002);
      @(negedge clk);
      check("wr_no_rvalid", 256'(bus_if.rvalid_o), 256'(4'b0000));
      check("wr_rr_wrap",   256'(bus_if.gnt_o),    256'(4'b0010));

      // write granted to a port receiving rvalid
      next_cycle();
      idle_reqs();
      set_port(1, 8'h01, 1'b1, 12'h001);
      @(negedge clk);
      check("wr_rsp_rvalid", 256'(bus_if.rvalid_o), 256'(4'b0010));
      check("wr_rsp_gnt",    256'(bus_if.gnt_o),    256'(4'b0010));
      check("wr_rsp_we",     256'(ram_we),          256'(1'b1));
      next_cycle();
      idle_reqs();
      @(negedge clk);
      check("wr_rsp_none", 256'(bus_if.rvalid_o), 256'(4'b0000));

      // reset during a port-2 read grant (rr_q is 2 here)
      next_cycle();
      set_port(2, 8'h01, 1'b0, 12'h0AA);
      @(negedge clk);
      check("rst_gnt_p2", 256'(bus_if.gnt_o), 256'(4'b0100));
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mh_clear", 256'(bus_if.multihit_o), 256'(1'b0));
      next_cycle();
      idle_reqs();
      @(negedge clk);
      check("rst_drop_rvalid", 256'(bus_if.rvalid_o),  256'(4'b0000));
      check("rst_drop_hit",    256'(bus_if.hit_way_o), 256'(8'h00));
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_rvalid", 256'(bus_if.rvalid_o), 256'(4'b0000));
      next_cycle();
      set_port(1, 8'h01, 1'b0, 12'h011);
      set_port(3, 8'h01, 1'b0, 12'h033);
      @(negedge clk);
      check("rel_gnt_p1", 256'(bus_if.gnt_o), 256'(4'b0010));
      next_cycle();
      idle_reqs();
      @(negedge clk);
      check("rel_rvalid_p1", 256'(bus_if.rvalid_o), 256'(4'b0010));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
